// File: rtl/data_path.sv
// ============================================================================
// Module   : data_path
// Brief    : IR/PC/NPC/PSR datapath with operand muxes, extender, ALU and a
//            SPARC-style Bicc branch evaluator (build with DATA_PATH_BLA_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_path (
    input  logic        Clk,
    input  logic        RESET,
    input  logic        IR_Enable,
    input  logic [31:0] IR_In,
    input  logic        PC_enable,
    input  logic        PC_Clr,
    input  logic        NPC_enable,
    input  logic        NPC_Clr,
    input  logic        PSR_Enable,
    input  logic        PSR_Clr,
    input  logic [1:0]  PC_In_Mux_select,
    input  logic [1:0]  ALUA_Mux_select,
    input  logic [2:0]  ALUB_Mux_select,
    input  logic [5:0]  ALU_op,
    input  logic [2:0]  extender_select,
    output logic [31:0] IR_Out,
    output logic [31:0] PC_out,
    output logic [31:0] NPC_out,
    output logic [31:0] PSR_out,
    output logic [31:0] ALU_Out,
    output logic [31:0] ALUA_Mux_out,
    output logic [31:0] ALUB_Mux_out,
    output logic [31:0] extender_out,
    output logic        out_BLA,
    output logic        BA_O,
    output logic        BN_O
);

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_AND = 6'b000001;
    localparam logic [5:0] OP_OR  = 6'b000010;
    localparam logic [5:0] OP_XOR = 6'b000011;
    localparam logic [5:0] OP_SUB = 6'b000100;

    logic [31:0] pc_mux_out;
    logic [32:0] add_res;
    logic [32:0] sub_res;
    logic        flag_n;
    logic        flag_z;
    logic        flag_v;
    logic        flag_c;

    always_comb begin
        case (extender_select)
            3'b000:  extender_out = {{8{IR_Out[21]}}, IR_Out[21:0], 2'b00};
            3'b001:  extender_out = {{19{IR_Out[12]}}, IR_Out[12:0]};
            3'b010:  extender_out = {IR_Out[21:0], 10'b0};
            default: extender_out = 32'h0;
        endcase
    end

    always_comb begin
        case (ALUA_Mux_select)
            2'b01:   ALUA_Mux_out = PC_out;
            2'b10:   ALUA_Mux_out = NPC_out;
            default: ALUA_Mux_out = 32'h0;
        endcase
    end

    always_comb begin
        case (ALUB_Mux_select)
            3'b110:  ALUB_Mux_out = 32'd4;
            3'b111:  ALUB_Mux_out = 32'h0;
            default: ALUB_Mux_out = extender_out;
        endcase
    end

    // Bit 32 of the widened subtraction is the borrow.
    assign add_res = {1'b0, ALUA_Mux_out} + {1'b0, ALUB_Mux_out};
    assign sub_res = {1'b0, ALUA_Mux_out} - {1'b0, ALUB_Mux_out};

    always_comb begin
        ALU_Out = ALUA_Mux_out;
        flag_c  = 1'b0;
        flag_v  = 1'b0;
        case (ALU_op)
            OP_ADD: begin
                ALU_Out = add_res[31:0];
                flag_c  = add_res[32];
                flag_v  = (ALUA_Mux_out[31] == ALUB_Mux_out[31]) &&
                          (add_res[31] != ALUA_Mux_out[31]);
            end
            OP_SUB: begin
                ALU_Out = sub_res[31:0];
                flag_c  = sub_res[32];
                flag_v  = (ALUA_Mux_out[31] != ALUB_Mux_out[31]) &&
                          (sub_res[31] != ALUA_Mux_out[31]);
            end
            OP_AND:  ALU_Out = ALUA_Mux_out & ALUB_Mux_out;
            OP_OR:   ALU_Out = ALUA_Mux_out | ALUB_Mux_out;
            OP_XOR:  ALU_Out = ALUA_Mux_out ^ ALUB_Mux_out;
            default: ALU_Out = ALUA_Mux_out;
        endcase
    end

    assign flag_n = ALU_Out[31];
    assign flag_z = (ALU_Out == 32'h0);

    always_comb begin
        case (PC_In_Mux_select)
            2'b00:   pc_mux_out = NPC_out;
            2'b01:   pc_mux_out = ALU_Out;
            default: pc_mux_out = 32'h0;
        endcase
    end

    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            IR_Out  <= 32'h0;
            PC_out  <= 32'h0;
            NPC_out <= 32'h0;
            PSR_out <= 32'h0;
        end else begin
            if (IR_Enable)
                IR_Out <= IR_In;

            if (PC_Clr)
                PC_out <= 32'h0;
            else if (PC_enable)
                PC_out <= pc_mux_out;

            if (NPC_Clr)
                NPC_out <= 32'h0;
            else if (NPC_enable)
                NPC_out <= ALU_Out;

            if (PSR_Clr)
                PSR_out <= 32'h0;
            else if (PSR_Enable)
                PSR_out[23:20] <= {flag_n, flag_z, flag_v, flag_c};
        end
    end

`ifdef DATA_PATH_BLA_EN
    logic       is_bicc;
    logic [3:0] cond;
    logic       icc_n;
    logic       icc_z;
    logic       icc_v;
    logic       icc_c;
    logic       base_cond;

    assign is_bicc = (IR_Out[31:30] == 2'b00) && (IR_Out[24:22] == 3'b010);
    assign cond    = IR_Out[28:25];
    assign {icc_n, icc_z, icc_v, icc_c} = PSR_out[23:20];

    // Upper half of the condition table is the complement of the lower half.
    always_comb begin
        case (cond[2:0])
            3'b001:  base_cond = icc_z;
            3'b010:  base_cond = icc_z | (icc_n ^ icc_v);
            3'b011:  base_cond = icc_n ^ icc_v;
            3'b100:  base_cond = icc_c | icc_z;
            3'b101:  base_cond = icc_c;
            3'b110:  base_cond = icc_n;
            3'b111:  base_cond = icc_v;
            default: base_cond = 1'b0;
        endcase
    end

    assign out_BLA = is_bicc & (base_cond ^ cond[3]);
    assign BA_O    = is_bicc & (cond == 4'b1000);
    assign BN_O    = is_bicc & (cond == 4'b0000);
`else
    assign out_BLA = 1'b0;
    assign BA_O    = 1'b0;
    assign BN_O    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_path.sv
// ============================================================================
// Module   : tb_data_path
// Brief    : Directed self-checking bench for data_path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_path;

`ifdef DATA_PATH_BLA_EN
    localparam bit BLA_ON = 1'b1;
`else
    localparam bit BLA_ON = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        RESET;
    logic        IR_Enable;
    logic [31:0] IR_In;
    logic        PC_enable, PC_Clr, NPC_enable, NPC_Clr, PSR_Enable, PSR_Clr;
    logic [1:0]  PC_In_Mux_select, ALUA_Mux_select;
    logic [2:0]  ALUB_Mux_select, extender_select;
    logic [5:0]  ALU_op;
    logic [31:0] IR_Out, PC_out, NPC_out, PSR_out;
    logic [31:0] ALU_Out, ALUA_Mux_out, ALUB_Mux_out, extender_out;
    logic        out_BLA, BA_O, BN_O;

    int errors = 0;
    int checks = 0;

    data_path dut (
        .Clk              (Clk),
        .RESET            (RESET),
        .IR_Enable        (IR_Enable),
        .IR_In            (IR_In),
        .PC_enable        (PC_enable),
        .PC_Clr           (PC_Clr),
        .NPC_enable       (NPC_enable),
        .NPC_Clr          (NPC_Clr),
        .PSR_Enable       (PSR_Enable),
        .PSR_Clr          (PSR_Clr),
        .PC_In_Mux_select (PC_In_Mux_select),
        .ALUA_Mux_select  (ALUA_Mux_select),
        .ALUB_Mux_select  (ALUB_Mux_select),
        .ALU_op           (ALU_op),
        .extender_select  (extender_select),
        .IR_Out           (IR_Out),
        .PC_out           (PC_out),
        .NPC_out          (NPC_out),
        .PSR_out          (PSR_out),
        .ALU_Out          (ALU_Out),
        .ALUA_Mux_out     (ALUA_Mux_out),
        .ALUB_Mux_out     (ALUB_Mux_out),
        .extender_out     (extender_out),
        .out_BLA          (out_BLA),
        .BA_O             (BA_O),
        .BN_O             (BN_O)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_ir(input logic [31:0] v);
        IR_In = v;
        IR_Enable = 1'b1;
        tick();
        IR_Enable = 1'b0;
    endtask

    // Expected {out_BLA, BA_O, BN_O}, zero when the evaluator is not built.
    function automatic logic [31:0] br(input logic [2:0] v);
        return BLA_ON ? {29'd0, v} : 32'd0;
    endfunction

    task automatic check_br(input string tag, input logic [31:0] ir, input logic [2:0] v);
        load_ir(ir);
        check(tag, {29'd0, out_BLA, BA_O, BN_O}, br(v));
    endtask

    initial begin
        RESET = 1'b0; IR_Enable = 1'b0; IR_In = 32'h0;
        PC_enable = 1'b0; PC_Clr = 1'b0; NPC_enable = 1'b0; NPC_Clr = 1'b0;
        PSR_Enable = 1'b0; PSR_Clr = 1'b0;
        PC_In_Mux_select = 2'b00; ALUA_Mux_select = 2'b00;
        ALUB_Mux_select = 3'b111; ALU_op = 6'b000000; extender_select = 3'b000;
        tick(); tick();
        check("rst_ir",  IR_Out,  32'h0);
        check("rst_pc",  PC_out,  32'h0);
        check("rst_npc", NPC_out, 32'h0);
        check("rst_psr", PSR_out, 32'h0);
        check("rst_br",  {29'd0, out_BLA, BA_O, BN_O}, 32'h0);
        RESET = 1'b1;

        // PC <= ALU(0+0), then NPC <= PC+4
        PC_In_Mux_select = 2'b01; PC_enable = 1'b1;
        tick(); PC_enable = 1'b0;
        check("pc_first", PC_out, 32'h0);
        ALUA_Mux_select = 2'b01; ALUB_Mux_select = 3'b110; NPC_enable = 1'b1;
        #1 check("alu_pc4", ALU_Out, 32'd4);
        tick(); NPC_enable = 1'b0;
        check("npc_first", NPC_out, 32'd4);

        PC_In_Mux_select = 2'b00; PC_enable = 1'b1;
        tick(); PC_enable = 1'b0;
        check("pc_from_npc", PC_out, 32'd4);
        NPC_enable = 1'b1;
        tick(); NPC_enable = 1'b0;
        check("npc_step", NPC_out, 32'd8);

        PC_In_Mux_select = 2'b10; PC_enable = 1'b1;
        tick();
        check("pc_mux_zero", PC_out, 32'h0);
        PC_In_Mux_select = 2'b00; PC_Clr = 1'b1;
        tick(); PC_enable = 1'b0; PC_Clr = 1'b0;
        check("pc_clr_wins", PC_out, 32'h0);
        PC_enable = 1'b1;
        tick(); PC_enable = 1'b0;
        check("pc_hold_src", PC_out, 32'd8);
        tick();
        check("pc_hold", PC_out, 32'd8);

        ALUA_Mux_select = 2'b00; #1 check("alua_00", ALUA_Mux_out, 32'h0);
        ALUA_Mux_select = 2'b10; #1 check("alua_10", ALUA_Mux_out, 32'd8);
        ALUA_Mux_select = 2'b11; #1 check("alua_11", ALUA_Mux_out, 32'h0);

        load_ir(32'h0000_1FFF);
        check("ir_load", IR_Out, 32'h0000_1FFF);
        ALUB_Mux_select = 3'b000;
        extender_select = 3'b000; #1 check("ext_000", extender_out, 32'h0000_7FFC);
        extender_select = 3'b001; #1 check("ext_001", extender_out, 32'hFFFF_FFFF);
        extender_select = 3'b010; #1 check("ext_010", extender_out, 32'h007F_FC00);
        extender_select = 3'b011; #1 check("ext_011", extender_out, 32'h0);
        ALUB_Mux_select = 3'b011; #1 check("alub_ext", ALUB_Mux_out, 32'h0);

        // A = NPC (8), B = 0xFFFFFFFF
        ALUA_Mux_select = 2'b10; extender_select = 3'b001;
        ALU_op = 6'b000000; #1 check("alu_add", ALU_Out, 32'h0000_0007);
        PSR_Enable = 1'b1; tick(); PSR_Enable = 1'b0;
        check("psr_add", PSR_out, 32'h0010_0000);
        ALU_op = 6'b000100; #1 check("alu_sub", ALU_Out, 32'h0000_0009);
        ALU_op = 6'b000001; #1 check("alu_and", ALU_Out, 32'h0000_0008);
        ALU_op = 6'b000011; #1 check("alu_xor", ALU_Out, 32'hFFFF_FFF7);
        ALU_op = 6'b000101; #1 check("alu_pass", ALU_Out, 32'h0000_0008);
        ALU_op = 6'b000010; #1 check("alu_or", ALU_Out, 32'hFFFF_FFFF);
        PSR_Enable = 1'b1; tick(); PSR_Enable = 1'b0;
        check("psr_or", PSR_out, 32'h0080_0000);

        // 0 - 0x80000000: negative, overflow, borrow
        load_ir(32'h0020_0000);
        ALUA_Mux_select = 2'b00; extender_select = 3'b010; ALU_op = 6'b000100;
        #1 check("alu_ovf", ALU_Out, 32'h8000_0000);
        PSR_Enable = 1'b1; tick(); PSR_Enable = 1'b0;
        check("psr_ovf", PSR_out, 32'h00B0_0000);
        PSR_Clr = 1'b1; PSR_Enable = 1'b1; tick(); PSR_Clr = 1'b0; PSR_Enable = 1'b0;
        check("psr_clr_wins", PSR_out, 32'h0);

        ALUB_Mux_select = 3'b111;
        PSR_Enable = 1'b1; tick(); PSR_Enable = 1'b0;
        check("psr_zero", PSR_out, 32'h0040_0000);

        // Z=1, N=V=C=0
        check_br("bn_a0",   32'h00A6_8003, 3'b001);
        check_br("bn_a1",   32'h20A6_8003, 3'b001);
        check_br("ba_a0",   32'h10A0_8003, 3'b110);
        check_br("ba_a1",   32'h30A0_8003, 3'b110);
        check_br("ble_a0",  32'h04A0_8003, 3'b100);
        check_br("ble_a1",  32'h24A0_8003, 3'b100);
        check_br("bcs_a0",  32'h0AA0_8003, 3'b000);
        check_br("bcs_a1",  32'h2AA0_8003, 3'b000);
        check_br("be",      32'h02A6_8003, 3'b100);
        check_br("bne",     32'h12A0_8003, 3'b000);
        check_br("non_bicc", 32'h8000_0000, 3'b000);

        // Asynchronous reset mid-cycle with PC enabled
        load_ir(32'h1234_5678);
        PC_In_Mux_select = 2'b00; PC_enable = 1'b1;
        ALUB_Mux_select = 3'b110;
        #3 RESET = 1'b0;
        #1;
        check("arst_ir",  IR_Out,  32'h0);
        check("arst_pc",  PC_out,  32'h0);
        check("arst_npc", NPC_out, 32'h0);
        check("arst_psr", PSR_out, 32'h0);
        check("arst_alub", ALUB_Mux_out, 32'd4);
        NPC_enable = 1'b1; PSR_Enable = 1'b1; IR_Enable = 1'b1;
        tick();
        check("arst_hold_npc", NPC_out, 32'h0);
        check("arst_hold_ir",  IR_Out,  32'h0);
        PC_enable = 1'b0; PSR_Enable = 1'b0; IR_Enable = 1'b0;
        ALUA_Mux_select = 2'b01; ALU_op = 6'b000000;
        #2 RESET = 1'b1;
        tick(); NPC_enable = 1'b0;
        check("post_rst_npc", NPC_out, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
